// File: rtl/ibex_cap_rf_clear_ctrl.sv
// Capability register file write-port scheduler: core writeback vs. bulk NullCap clear engine.
// Optional macro IBEX_CAP_CLR_FAIR_EN adds a bounded-starvation guarantee for the clear engine.
module ibex_cap_rf_clear_ctrl #(
  parameter bit                   RV32E     = 1'b0,
  parameter int unsigned          DataWidth = 93,
  parameter logic [DataWidth-1:0] NullCap   = 93'h1F690003F0,
  parameter int unsigned          MaxStall  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_req_i,
  input  logic [31:0]          clr_mask_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic [31:0]          clr_pending_o,
  input  logic                 wb_req_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 wb_gnt_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pending;
  logic        r_done;

  logic        w_sweep;
  logic        w_force;
  logic        w_gnt;
  logic        w_core_wr;
  logic        w_eng_wr;
  logic [4:0]  w_sel;
  logic [31:0] w_eff_mask;
  logic [31:0] w_core_clr;
  logic [31:0] w_eng_clr;
  logic [31:0] w_pending_nxt;

  // x0 is never cleared; RV32E has no x16..x31.
  function automatic logic [31:0] eff_mask(input logic [31:0] mask);
    logic [31:0] m;
    m = mask & 32'hFFFF_FFFE;
    if (RV32E) m[31:16] = 16'h0000;
    return m;
  endfunction

  // Lowest set bit wins; bit 0 can never be pending.
  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 1; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  assign w_sweep    = (r_state == ST_SWEEP);
  assign w_eff_mask = eff_mask(clr_mask_i);
  assign w_gnt      = ~w_force;
  assign w_core_wr  = wb_req_i & w_gnt;
  assign w_eng_wr   = w_sweep & ~w_core_wr & (r_pending != 32'h0);
  assign w_sel      = lowest_idx(r_pending);

  // A granted core write is younger than the clear, so it retires that register's pending bit.
  assign w_core_clr    = (w_core_wr && (wb_addr_i != 5'd0)) ? (32'h1 << wb_addr_i) : 32'h0;
  assign w_eng_clr     = w_eng_wr ? (32'h1 << w_sel) : 32'h0;
  assign w_pending_nxt = r_pending & ~w_core_clr & ~w_eng_clr;

`ifdef IBEX_CAP_CLR_FAIR_EN
  localparam int unsigned CntW = (MaxStall < 1) ? 1 : $clog2(MaxStall + 1);

  logic [CntW-1:0] r_stall_cnt;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntW'(MaxStall)) ? v : v + 1'b1;
  endfunction

  assign w_force = w_sweep & (r_stall_cnt == CntW'(MaxStall));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_sweep && w_core_wr && (w_pending_nxt != 32'h0)) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end else begin
      r_stall_cnt <= '0;
    end
  end
`else
  logic w_unused_max_stall;

  assign w_force            = 1'b0;
  assign w_unused_max_stall = (MaxStall != 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_pending <= 32'h0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr_req_i) begin
            if (w_eff_mask != 32'h0) begin
              r_state   <= ST_SWEEP;
              r_pending <= w_eff_mask;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_SWEEP: begin
          r_pending <= w_pending_nxt;
          if (w_pending_nxt == 32'h0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    if (w_core_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_addr_i;
      rf_wdata_o = wb_data_i;
    end else if (w_eng_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = w_sel;
      rf_wdata_o = NullCap;
    end
  end

  assign wb_gnt_o      = w_gnt;
  assign clr_busy_o    = (r_state != ST_IDLE);
  assign clr_done_o    = r_done;
  assign clr_pending_o = r_pending;

endmodule
